// File: rtl/wb_master_pkg.sv
// Shared types and Wishbone encodings for the burst master.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_wdata_hold.sv
// One-entry write-data holding register between the write stream and wb_dat_o.
module wb_wdata_hold #(
    parameter int dw = 32
) (
    input  logic          sys_clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          enable,
    input  logic          in_valid,
    input  logic [dw-1:0] in_data,
    input  logic          pop,
    output logic          in_ready,
    output logic          full,
    output logic [dw-1:0] data
);

    logic          full_q;
    logic [dw-1:0] data_q;
    logic          load;

    // A pop in the same cycle frees the slot, so a beat per cycle can stream through.
    assign in_ready = enable && (!full_q || pop);
    assign load     = in_valid && in_ready;

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (clear)
                full_q <= 1'b0;
            else if (load)
                full_q <= 1'b1;
            else if (pop)
                full_q <= 1'b0;
            if (load)
                data_q <= in_data;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator fed by a command/stream interface.
// Optional ack timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
//
// state   | meaning
// ST_IDLE | cmd_ready high, waiting for a command
// ST_BUS  | cyc held, beats transferred until the last ack (or timeout)
// ST_DONE | one-cycle done pulse, bus released
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw      = 32,
    parameter int APP_AW  = 26,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [dw/8-1:0]   cmd_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [dw-1:0]     wr_data,
    output logic              rd_valid,
    output logic [dw-1:0]     rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i
);

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("wb_burst_master: TIMEOUT must be at least 2");
    end

    state_e            state_q, state_d;
    logic              we_q;
    logic [APP_AW-1:0] addr_q;
    logic [dw/8-1:0]   sel_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  load_rem_q;
    logic              loads_done_q;
    logic              rd_valid_q, rd_last_q;
    logic [dw-1:0]     rd_data_q;

    logic accept, stb, ack_ok, last_beat, timeout_hit;
    logic hold_full, hold_en, hold_clear, wr_fire;

    assign accept     = (state_q == ST_IDLE) && cmd_valid;
    assign stb        = (state_q == ST_BUS) && (!we_q || hold_full);
    assign ack_ok     = stb && wb_ack_i;
    assign last_beat  = (cnt_q == '0);
    assign hold_en    = (state_q == ST_BUS) && we_q && !loads_done_q;
    assign hold_clear = accept || timeout_hit;
    assign wr_fire    = wr_valid && wr_ready;

    wb_wdata_hold #(.dw(dw)) u_hold (
        .sys_clk  (sys_clk),
        .resetn   (resetn),
        .clear    (hold_clear),
        .enable   (hold_en),
        .in_valid (wr_valid),
        .in_data  (wr_data),
        .pop      (ack_ok),
        .in_ready (wr_ready),
        .full     (hold_full),
        .data     (wb_dat_o)
    );

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUS;
            ST_BUS:  if ((ack_ok && last_beat) || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            load_rem_q   <= '0;
            loads_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            if (accept) begin
                we_q         <= cmd_we;
                addr_q       <= cmd_addr;
                sel_q        <= cmd_sel;
                cnt_q        <= cmd_len;
                load_rem_q   <= cmd_len;
                loads_done_q <= 1'b0;
            end
            if (ack_ok) begin
                addr_q <= addr_q + APP_AW'(1);
                cnt_q  <= cnt_q - LEN_W'(1);
            end
            // Separate load counter stops wr_ready once every beat is in hand.
            if (wr_fire) begin
                if (load_rem_q == '0)
                    loads_done_q <= 1'b1;
                else
                    load_rem_q <= load_rem_q - LEN_W'(1);
            end
            rd_valid_q <= ack_ok && !we_q;
            rd_last_q  <= ack_ok && !we_q && last_beat;
            if (ack_ok && !we_q)
                rd_data_q <= wb_dat_i;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);

    logic [TO_W-1:0] to_cnt_q;
    logic            stb_q, stb_rise, err_q;

    // Down-counter reloaded so terminal count lands on the TIMEOUT-th unacked stb cycle.
    assign stb_rise    = stb && !stb_q;
    assign timeout_hit = stb && !wb_ack_i && !stb_rise && (to_cnt_q == '0);

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            stb_q    <= 1'b0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            stb_q <= stb;
            if (ack_ok)
                to_cnt_q <= TO_W'(TIMEOUT - 1);
            else if (stb_rise)
                to_cnt_q <= TO_W'(TIMEOUT - 2);
            else if (stb && (to_cnt_q != '0))
                to_cnt_q <= to_cnt_q - TO_W'(1);
            if (accept)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign wb_cyc_o  = (state_q == ST_BUS);
    assign wb_stb_o  = stb;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_sel_o  = sel_q;
    assign wb_cti_o  = (state_q != ST_BUS) ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INCR);
    assign wb_bte_o  = BTE_LINEAR;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master against a beat-counting reference model.
module tb_wb_burst_master;

    logic        sys_clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [25:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_last, done, err, busy;
    logic [31:0] rd_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i;

    wb_burst_master #(.dw(32), .APP_AW(26), .LEN_W(8), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what the current burst should look like, by beat count.
    bit          mon_en = 0, active = 0, exp_we = 0, pend_rd = 0;
    int          exp_len = 0, acked = 0, rd_cnt = 0;
    logic [25:0] exp_base = '0;
    logic [3:0]  exp_sel = '0;
    logic [31:0] wq[$];
    int          wr_idx = 0;

    // Slave and write-source knobs.
    bit no_ack = 0, spurious_en = 0, wr_src_en = 0, ack_drv;
    int lat_min = 0, lat_max = 0, cur_lat = 0, wait_cnt = 0, gap_len = 0, gap_cnt = 0;
    bit in_bus, e_stb;
    logic [25:0] e_addr;

    always begin
        @(negedge sys_clk);
        if (wb_stb_o) begin
            ack_drv = !no_ack && (wait_cnt >= cur_lat);
            if (!ack_drv) wait_cnt++;
        end else begin
            wait_cnt = 0;
            ack_drv  = spurious_en && ($urandom_range(3) == 0);
        end
        wb_ack_i = ack_drv;
        wb_dat_i = (wb_stb_o && ack_drv) ? (32'hA5A5_0000 + 32'(acked) + 32'd1) : $urandom;
        wr_valid = wr_src_en && (gap_cnt == 0);
        wr_data  = (wr_idx < wq.size()) ? wq[wr_idx] : 32'hDEAD_BEEF;
        #1;
        if (mon_en) begin
            in_bus = active && (acked <= exp_len);
            e_stb  = in_bus && (!exp_we || (wr_idx > acked));
            check("cyc", wb_cyc_o, in_bus);
            check("stb", wb_stb_o, e_stb);
            check("cti", wb_cti_o, in_bus ? ((acked == exp_len) ? 32'd7 : 32'd2) : 32'd0);
            check("busy", busy, active);
            check("cmd_ready", cmd_ready, !active);
            check("wr_ready", wr_ready, in_bus && exp_we && (wr_idx <= exp_len) &&
                  ((wr_idx == acked) || (e_stb && wb_ack_i)));
            check("rd_valid", rd_valid, pend_rd);
            check("bte", wb_bte_o, 0);
`ifndef WB_MASTER_TIMEOUT_EN
            check("err", err, 0);
`endif
            if (e_stb) begin
                e_addr = exp_base + 26'(acked);
                check("addr", wb_addr_o, e_addr);
                check("we", wb_we_o, exp_we);
                check("sel", wb_sel_o, exp_sel);
                if (exp_we && acked < wq.size()) check("wdata", wb_dat_o, wq[acked]);
            end
            if (pend_rd) begin
                check("rd_data", rd_data, 32'hA5A5_0000 + 32'(rd_cnt) + 32'd1);
                check("rd_last", rd_last, rd_cnt == exp_len);
                rd_cnt++;
            end
            check("done", done, active && (acked == exp_len + 1));
            if (active && (acked == exp_len + 1)) begin
                if (!exp_we) check("rd_count", rd_cnt, exp_len + 1);
                active = 0;
            end
        end
        pend_rd = active && !exp_we && wb_stb_o && wb_ack_i;
        if (wb_stb_o && wb_ack_i) begin
            acked++;
            wait_cnt = 0;
            cur_lat  = $urandom_range(lat_max, lat_min);
        end
        if (wr_valid && wr_ready) begin
            if (mon_en) check("wr_extra", wr_idx < wq.size(), 1);
            wr_idx++;
            gap_cnt = gap_len;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
    end

    task automatic set_lat(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
        cur_lat = $urandom_range(hi, lo);
    endtask

    task automatic issue(input bit we, input logic [25:0] addr, input int len, input logic [3:0] sel);
        bit got;
        wq.delete();
        if (we) for (int i = 0; i <= len; i++) wq.push_back($urandom);
        wr_idx  = 0;
        gap_cnt = 0;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        cmd_sel   = sel;
        got = 0;
        for (int t = 0; t < 200; t++) begin
            if (cmd_ready) begin got = 1; break; end
            @(negedge sys_clk);
        end
        check("cmd_accept", got, 1);
        if (got) begin
            @(posedge sys_clk);
            active   = 1;
            acked    = 0;
            rd_cnt   = 0;
            pend_rd  = 0;
            exp_we   = we;
            exp_base = addr;
            exp_len  = len;
            exp_sel  = sel;
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (active && t < budget) begin
            @(negedge sys_clk);
            #2;
            t++;
        end
        check("done_timeout", active, 0);
        active = 0;
    endtask

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_sel   = '0;
        repeat (3) @(posedge sys_clk);
        #3 resetn = 1'b1;
        @(negedge sys_clk);
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_err", err, 0);
        check("rst_cti", wb_cti_o, 0);
        check("rst_addr", wb_addr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_wr_ready", wr_ready, 0);

        mon_en    = 1;
        wr_src_en = 1;

        // Single read, ack after two wait cycles.
        set_lat(2, 2);
        issue(0, 26'h100, 0, 4'hF);
        wait_done(50);
        check("single_rd_count", rd_cnt, 1);

        // 8-beat write wrapping the top of the address space, full rate.
        set_lat(0, 0);
        issue(1, 26'h3FF_FFFC, 7, 4'hF);
        wait_done(100);
        check("wr8_accepts", wr_idx, 8);

        // 4-beat write with 3-cycle wr_valid gaps and stray acks while stb is low.
        gap_len     = 3;
        spurious_en = 1;
        issue(1, 26'h0000_040, 3, 4'h5);
        wait_done(100);
        check("wrgap_accepts", wr_idx, 4);
        gap_len = 0;

        // 256-beat read with random stalls.
        set_lat(0, 3);
        issue(0, $urandom, 255, 4'hF);
        wait_done(2000);
        check("rd256_count", rd_cnt, 256);

        // Random mix of bursts.
        for (int n = 0; n < 8; n++) begin
            set_lat(0, $urandom_range(3));
            gap_len = $urandom_range(2);
            issue($urandom_range(1), $urandom, $urandom_range(15), $urandom);
            wait_done(400);
        end
        gap_len = 0;

        // Reset in the middle of an 8-beat read.
        set_lat(0, 0);
        issue(0, 26'h2000, 7, 4'hF);
        for (int t = 0; t < 100 && acked < 3; t++) @(posedge sys_clk);
        #3;
        mon_en = 0;
        resetn = 1'b0;
        #1;
        check("arst_cyc", wb_cyc_o, 0);
        check("arst_stb", wb_stb_o, 0);
        check("arst_busy", busy, 0);
        for (int t = 0; t < 3; t++) begin
            @(negedge sys_clk);
            #2 check("arst_no_done", done, 0);
        end
        @(posedge sys_clk);
        #3 resetn = 1'b1;
        active  = 0;
        acked   = 0;
        pend_rd = 0;
        rd_cnt  = 0;
        wq.delete();
        wr_idx  = 0;
        @(negedge sys_clk);
        #2 check("post_rst_done", done, 0);
        mon_en = 1;
        issue(0, 26'h2000, 7, 4'hF);
        wait_done(100);
        check("post_rst_rd_count", rd_cnt, 8);

`ifdef WB_MASTER_TIMEOUT_EN
        begin
            int  stb_cnt;
            bit  got;
            mon_en  = 0;
            no_ack  = 1;
            stb_cnt = 0;
            got     = 0;
            issue(0, 26'h55, 3, 4'hF);
            for (int t = 0; t < 200; t++) begin
                @(negedge sys_clk);
                #2;
                if (done) begin got = 1; break; end
                if (wb_stb_o) stb_cnt++;
            end
            check("to_done_seen", got, 1);
            check("to_stb_cycles", stb_cnt, 16);
            check("to_err", err, 1);
            check("to_cyc", wb_cyc_o, 0);
            check("to_no_rd", rd_cnt, 0);
            @(negedge sys_clk);
            #2;
            check("to_err_sticky", err, 1);
            check("to_done_once", done, 0);
            check("to_idle", cmd_ready, 1);
            active  = 0;
            acked   = 0;
            pend_rd = 0;
            no_ack  = 0;
            mon_en  = 1;
            issue(0, 26'h123, 0, 4'hF);
            check("to_err_clear", err, 0);
            wait_done(100);
        end
`endif

        repeat (3) @(posedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
